// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: matrix geometry and shared types for the keypad scanner.
// Shared by keypad_scan and keypad_row_sync.
package keypad_scan_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 5;
  localparam int NKEYS = ROWS * COLS;

  typedef enum logic [1:0] {
    SETTLE,
    SAMPLE,
    FRAME_END
  } scan_state_t;

  typedef logic [NKEYS-1:0] key_vec_t;

  function automatic logic [4:0] popcnt(input key_vec_t v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NKEYS; i++)
      n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic logic [COLS-1:0] col_drive(
    input logic [2:0] idx
  );
    return ~(COLS'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: 2-flop synchronizer for the active-low row pins.
// Output is active-high (1 = row pulled low by a pressed key).
module keypad_row_sync
  import keypad_scan_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] i_row_n,
  output logic [ROWS-1:0] o_row_s
);

  logic [ROWS-1:0] r_meta;
  logic [ROWS-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= ~i_row_n;
      r_sync <= r_meta;
    end
  end

  assign o_row_s = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x5 matrix scanner with whole-frame debounce.
// Define KEYPAD_SCAN_GHOST_REJECT_EN to drop frames with >2 keys.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  output key_vec_t        keys,
  output logic            keys_changed
);

  localparam logic [7:0] SETTLE_LAST =
    8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] STABLE_MAX =
    4'(DEBOUNCE_FRAMES - 1);

  scan_state_t     r_state;
  logic [7:0]      r_cnt;
  logic [2:0]      r_col_idx;
  logic [COLS-1:0] r_col_n;
  key_vec_t        r_frame;
  key_vec_t        r_prev;
  logic [3:0]      r_stable;
  key_vec_t        r_keys;
  logic            r_changed;

  logic [ROWS-1:0] w_row_s;
  key_vec_t        w_frame_nxt;
  logic            w_same;
  logic            w_valid;
  logic [3:0]      w_stable_nxt;
  logic            w_publish;

  keypad_row_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_row_n (row_n),
    .o_row_s (w_row_s)
  );

  always_comb begin
    w_frame_nxt = r_frame;
    for (int c = 0; c < COLS; c++)
      if (r_col_idx == 3'(c))
        for (int r = 0; r < ROWS; r++)
          w_frame_nxt[r*COLS+c] = w_row_s[r];
  end

  always_comb begin
    w_same = (r_frame == r_prev);
    if (!w_same)
      w_stable_nxt = '0;
    else if (r_stable == STABLE_MAX)
      w_stable_nxt = r_stable;
    else
      w_stable_nxt = r_stable + 4'd1;
`ifdef KEYPAD_SCAN_GHOST_REJECT_EN
    w_valid = (popcnt(r_frame) <= 5'd2);
`else
    w_valid = 1'b1;
`endif
    w_publish = w_valid
      && (w_stable_nxt == STABLE_MAX)
      && (r_frame != r_keys);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= SETTLE;
      r_cnt     <= '0;
      r_col_idx <= '0;
      r_col_n   <= '1;
      r_frame   <= '0;
      r_prev    <= '0;
      r_stable  <= '0;
      r_keys    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      unique case (r_state)
        SETTLE: begin
          // all-ones only right after reset: enter column 0 first
          if (&r_col_n)
            r_col_n <= col_drive(r_col_idx);
          else if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= SAMPLE;
          end else
            r_cnt <= r_cnt + 8'd1;
        end
        SAMPLE: begin
          r_frame <= w_frame_nxt;
          if (r_col_idx == 3'(COLS - 1)) begin
            r_col_n <= '1;
            r_state <= FRAME_END;
          end else begin
            r_col_idx <= r_col_idx + 3'd1;
            r_col_n   <= col_drive(r_col_idx + 3'd1);
            r_state   <= SETTLE;
          end
        end
        FRAME_END: begin
          r_stable <= w_valid ? w_stable_nxt : '0;
          if (w_valid && !w_same)
            r_prev <= r_frame;
          if (w_publish) begin
            r_keys    <= r_frame;
            r_changed <= 1'b1;
          end
          r_frame   <= '0;
          r_col_idx <= '0;
          r_col_n   <= col_drive(3'd0);
          r_state   <= SETTLE;
        end
        default: r_state <= SETTLE;
      endcase
    end
  end

  assign col_n        = r_col_n;
  assign keys         = r_keys;
  assign keys_changed = r_changed;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: vector table plus scoreboard of change pulses.
// Expected keys are queued on stimulus and popped on keys_changed.
module tb_keypad_scan;

  localparam int SC = 4;
  localparam int DF = 3;
  localparam int F  = 5 * (SC + 1) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [4:0]  col_n;
  logic [19:0] keys;
  logic        keys_changed;
  logic [19:0] pressed = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  logic [19:0] exp_q[$];

  typedef struct {
    logic [19:0] press;
    logic [19:0] exp;
  } vec_t;
  vec_t vecs[9];

  keypad_scan #(
    .SETTLE_CYCLES   (SC),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_n        (row_n),
    .col_n        (col_n),
    .keys         (keys),
    .keys_changed (keys_changed)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      row_n[r] = ~|(pressed[r*5 +: 5] & ~col_n);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && keys_changed) begin
      n_pulse++;
      check("pulse_expected", exp_q.size(), 1);
      if (exp_q.size() > 0)
        check("pulse_keys", keys, exp_q.pop_front());
    end
  end

  task automatic wait_col(input logic [4:0] c);
    int t;
    t = 0;
    while (col_n !== c && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("wait_col", col_n, c);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] cur;
    logic [4:0]  ec;
    int          p0;
    int          t;

    vecs[0] = '{20'h00000, 20'h00000};
    vecs[1] = '{20'h02000, 20'h02000};
    vecs[2] = '{20'h00000, 20'h00000};
`ifdef KEYPAD_SCAN_GHOST_REJECT_EN
    vecs[3] = '{20'h00023, 20'h00000};
`else
    vecs[3] = '{20'h00023, 20'h00023};
`endif
    vecs[4] = '{20'h00000, 20'h00000};
    vecs[5] = '{20'h00001, 20'h00001};
    vecs[6] = '{20'h00021, 20'h00021};
    vecs[7] = '{20'h80000, 20'h80000};
    vecs[8] = '{20'h00000, 20'h00000};

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_col_n", col_n, 5'b11111);
    check("rst_keys", keys, 20'h0);
    check("rst_changed", keys_changed, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_col", col_n, 5'b11110);

    for (int i = 0; i < 2 * F; i++) begin
      if ((i % F) < 25)
        ec = ~(5'b00001 << ((i % F) / 5));
      else
        ec = 5'b11111;
      check("sweep_col", col_n, ec);
      @(negedge clk);
    end
    check("sweep_keys", keys, 20'h0);
    check("sweep_pulses", n_pulse, 0);

    wait_col(5'b11111);
    pressed = 20'h02000;
    exp_q.push_back(20'h02000);
    t = 0;
    while (!keys_changed && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t < DF * F || t > (DF + 1) * F) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles need %0d..%0d",
               t, DF * F, (DF + 1) * F);
    end
    @(negedge clk);
    check("press_keys", keys, 20'h02000);
    cur = 20'h02000;

    for (int i = 0; i < 9; i++) begin
      p0 = n_pulse;
      pressed = vecs[i].press;
      if (vecs[i].exp != cur)
        exp_q.push_back(vecs[i].exp);
      repeat (5 * F) @(negedge clk);
      check("vec_keys", keys, vecs[i].exp);
      check("vec_pulses", n_pulse - p0,
            (vecs[i].exp != cur) ? 1 : 0);
      cur = vecs[i].exp;
    end

    wait_col(5'b11111);
    p0 = n_pulse;
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? 20'h02000 : 20'h0;
      repeat (F) @(negedge clk);
    end
    pressed = '0;
    repeat (5 * F) @(negedge clk);
    check("bounce_keys", keys, 20'h0);
    check("bounce_pulses", n_pulse - p0, 0);

    pressed = 20'h02000;
    exp_q.push_back(20'h02000);
    repeat (5 * F) @(negedge clk);
    check("pre_rst_keys", keys, 20'h02000);
    wait_col(5'b11011);
    rst_n = 1'b0;
    pressed = '0;
    @(negedge clk);
    check("mid_rst_col", col_n, 5'b11111);
    check("mid_rst_keys", keys, 20'h0);
    check("mid_rst_chg", keys_changed, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_col", col_n, 5'b11110);
    p0 = n_pulse;
    repeat (5 * F) @(negedge clk);
    check("post_rst_keys", keys, 20'h0);
    check("post_rst_pulses", n_pulse - p0, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
